// File: rtl/uart_tx_ctrl_if.sv
// Byte write port of the UART transmitter: push handshake plus FIFO occupancy.
interface uart_tx_ctrl_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                        wr_en;
    logic [7:0]                  wr_data;
    logic                        wr_ready;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    modport master (
        output wr_en,
        output wr_data,
        input  wr_ready,
        input  fifo_level
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output wr_ready,
        output fifo_level
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serialiser on tx.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic          clock,
    input  logic          reset,
    uart_tx_ctrl_if.slave wr,
    output logic          tx_busy,
    output logic          tx
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [LW-1:0] level;
    logic          ready;
    logic          push;
    logic          pop;
    logic          bit_done;

    assign ready         = (level != LVL_FULL);
    assign wr.wr_ready   = ready;
    assign wr.fifo_level = level;
    assign tx_busy       = (state != IDLE) || (level != '0);
    assign push          = wr.wr_en && ready;
    assign bit_done      = (baud_cnt == CNT_LAST);
    // Pop either to leave IDLE or at the last STOP cycle, so frames run back to back.
    assign pop           = (level != '0) && ((state == IDLE) || ((state == STOP) && bit_done));

    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem[wr_ptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase

            unique case (state)
                IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (pop) begin
                        shift_reg <= mem[rd_ptr];
                        bit_idx   <= '0;
                        tx        <= 1'b0;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        tx       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // tx takes the next bit directly so it stays registered
                            shift_reg <= shift_reg >> 1;
                            tx        <= shift_reg[1];
                            bit_idx   <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg <= mem[rd_ptr];
                            bit_idx   <= '0;
                            tx        <= 1'b0;
                            state     <= START;
                        end else begin
                            tx    <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: directed timing checks on a fast instance, random scoreboard on a second.
module tb_uart_tx_ctrl;
    logic clock;
    logic reset;
    logic tx0, busy0, tx1, busy1;

    uart_tx_ctrl_if #(.FIFO_DEPTH(4)) if0 ();
    uart_tx_ctrl_if #(.FIFO_DEPTH(8)) if1 ();

    uart_tx_ctrl #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset), .wr(if0), .tx_busy(busy0), .tx(tx0)
    );

    uart_tx_ctrl #(.CLKS_PER_BIT(7), .FIFO_DEPTH(8)) dut_r (
        .clock(clock), .reset(reset), .wr(if1), .tx_busy(busy1), .tx(tx1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int rst_epoch = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic exp_bits[$];

    typedef struct {
        logic       en;
        logic [7:0] data;
        logic       exp_ready;
        int         exp_level;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    // Expected FIFO contents: an accepted push is recorded at the edge that takes it.
    always @(posedge clock) begin
        if (!reset) begin
            q0.delete();
            q1.delete();
            rst_epoch++;
        end else begin
            if (if0.wr_en && if0.wr_ready) q0.push_back(if0.wr_data);
            if (if1.wr_en && if1.wr_ready) q1.push_back(if1.wr_data);
        end
    end

    function automatic logic line(input int which);
        return (which == 0) ? tx0 : tx1;
    endfunction

    // Serial receiver: samples each bit at its centre, drops frames cut by reset.
    task automatic rx_run(input int which, input int cpb);
        logic       prev;
        logic       s0, s9;
        logic [7:0] b;
        logic [31:0] exp;
        int         ep;
        wait (reset === 1'b1);
        prev = 1'b0;
        forever begin
            @(negedge clock);
            if (prev === 1'b1 && line(which) === 1'b0) begin
                ep = rst_epoch;
                repeat (cpb / 2) @(negedge clock);
                s0 = line(which);
                for (int k = 0; k < 8; k++) begin
                    repeat (cpb) @(negedge clock);
                    b[k] = line(which);
                end
                repeat (cpb) @(negedge clock);
                s9 = line(which);
                if (ep == rst_epoch) begin
                    exp = 32'h100;
                    if (which == 0 && q0.size() != 0) exp = {24'h0, q0.pop_front()};
                    if (which == 1 && q1.size() != 0) exp = {24'h0, q1.pop_front()};
                    check($sformatf("rx%0d start bit", which), {31'h0, s0}, 32'h0);
                    check($sformatf("rx%0d stop bit", which), {31'h0, s9}, 32'h1);
                    check($sformatf("rx%0d byte", which), {24'h0, b}, exp);
                end
            end
            prev = line(which);
        end
    endtask

    task automatic add_frame(input logic [7:0] d);
        exp_bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) exp_bits.push_back(d[k]);
        exp_bits.push_back(1'b1);
    endtask

    task automatic wait_drain(input int which, input int bound);
        logic done;
        done = 1'b0;
        for (int c = 0; c < bound && !done; c++) begin
            step();
            if (which == 0) done = !busy0 && (q0.size() == 0);
            else            done = !busy1 && (q1.size() == 0);
        end
        repeat (8) step();
        check($sformatf("drain%0d", which), {31'h0, done}, 32'h1);
    endtask

    initial begin
        int accepted;
        int lows;
        vecs[0] = '{1'b1, 8'h11, 1'b1, 1};
        vecs[1] = '{1'b1, 8'h12, 1'b1, 1};
        vecs[2] = '{1'b1, 8'h13, 1'b1, 2};
        vecs[3] = '{1'b1, 8'h14, 1'b1, 3};
        vecs[4] = '{1'b1, 8'h15, 1'b1, 4};
        vecs[5] = '{1'b1, 8'h16, 1'b0, 4};

        reset = 1'b0;
        if0.wr_en = 1'b0; if0.wr_data = '0;
        if1.wr_en = 1'b0; if1.wr_data = '0;
        fork
            rx_run(0, 4);
            rx_run(1, 7);
        join_none
        repeat (3) step();
        reset = 1'b1;
        step();

        check("reset tx", {31'h0, tx0}, 32'h1);
        check("reset level", {29'h0, if0.fifo_level}, 32'h0);
        check("reset ready", {31'h0, if0.wr_ready}, 32'h1);
        check("reset busy", {31'h0, busy0}, 32'h0);
        check("reset tx r", {31'h0, tx1}, 32'h1);

        // Single byte: one idle cycle at level 1, then a 40-cycle frame.
        if0.wr_en = 1'b1; if0.wr_data = 8'hA5;
        step();
        if0.wr_en = 1'b0;
        check("t1 tx before pop", {31'h0, tx0}, 32'h1);
        check("t1 level before pop", {29'h0, if0.fifo_level}, 32'h1);
        check("t1 busy", {31'h0, busy0}, 32'h1);
        exp_bits.delete();
        add_frame(8'hA5);
        for (int c = 0; c < 40; c++) begin
            step();
            check($sformatf("t1 tx cycle %0d", c), {31'h0, tx0}, {31'h0, exp_bits[c / 4]});
        end
        check("t1 busy last cycle", {31'h0, busy0}, 32'h1);
        step();
        check("t1 busy falls", {31'h0, busy0}, 32'h0);
        check("t1 tx idle", {31'h0, tx0}, 32'h1);
        wait_drain(0, 100);

        // Back-to-back frames with no idle gap.
        if0.wr_en = 1'b1; if0.wr_data = 8'h00;
        step();
        if0.wr_data = 8'hFF;
        exp_bits.delete();
        add_frame(8'h00);
        add_frame(8'hFF);
        for (int c = 0; c < 80; c++) begin
            step();
            if (c == 0) begin
                if0.wr_en = 1'b0;
                check("t2 level after two pushes", {29'h0, if0.fifo_level}, 32'h1);
            end
            check($sformatf("t2 tx cycle %0d", c), {31'h0, tx0}, {31'h0, exp_bits[c / 4]});
        end
        wait_drain(0, 100);

        // Fill the FIFO from IDLE; sixth push meets wr_ready=0.
        for (int i = 0; i < 6; i++) begin
            if0.wr_en = vecs[i].en; if0.wr_data = vecs[i].data;
            check($sformatf("t3 ready %0d", i), {31'h0, if0.wr_ready}, {31'h0, vecs[i].exp_ready});
            step();
            check($sformatf("t3 level %0d", i), {29'h0, if0.fifo_level}, vecs[i].exp_level);
        end
        if0.wr_en = 1'b0;

        // 0x11 frame began at the second push edge; we are 4 cycles in, its last stop cycle is 39.
        repeat (35) step();
        if0.wr_en = 1'b1; if0.wr_data = 8'h77;
        check("t4 ready on pop edge", {31'h0, if0.wr_ready}, 32'h0);
        step();
        check("t4 level after pop", {29'h0, if0.fifo_level}, 32'h3);
        check("t4 next start", {31'h0, tx0}, 32'h0);
        if0.wr_data = 8'h88;
        check("t4 ready after pop", {31'h0, if0.wr_ready}, 32'h1);
        step();
        if0.wr_en = 1'b0;
        check("t4 level refilled", {29'h0, if0.fifo_level}, 32'h4);
        wait_drain(0, 400);

        // Reset mid-frame with two bytes queued.
        if0.wr_en = 1'b1; if0.wr_data = 8'h3C;
        step();
        if0.wr_data = 8'h5A;
        step();
        if0.wr_data = 8'hC3;
        step();
        if0.wr_en = 1'b0;
        check("t5 level queued", {29'h0, if0.fifo_level}, 32'h2);
        repeat (16) step();
        check("t5 data bit 3", {31'h0, tx0}, 32'h1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("t5 tx after reset", {31'h0, tx0}, 32'h1);
        check("t5 level after reset", {29'h0, if0.fifo_level}, 32'h0);
        check("t5 busy after reset", {31'h0, busy0}, 32'h0);
        check("t5 ready after reset", {31'h0, if0.wr_ready}, 32'h1);
        lows = 0;
        for (int c = 0; c < 100; c++) begin
            step();
            if (tx0 !== 1'b1) lows++;
        end
        check("t5 no frames after reset", lows, 32'h0);

        // Random traffic with gaps into the second instance.
        accepted = 0;
        for (int c = 0; c < 30000 && accepted < 200; c++) begin
            if1.wr_en = ($urandom_range(0, 3) != 0);
            if1.wr_data = 8'($urandom_range(0, 255));
            if (if1.wr_en && if1.wr_ready) accepted++;
            step();
        end
        if1.wr_en = 1'b0;
        check("t6 accepted count", accepted, 32'd200);
        wait_drain(1, 2000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
